// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction fetch front end.
//
// Contents:
//   IFU_RESET_PC  - default fetch address after reset
//   IFU_MEM_LAST  - default highest valid word address of instruction memory
//   NOP_WORD      - value presented on the instruction output when nothing is queued
//   fetch_entry_t - one prefetch queue entry {pc, instr}
//   EMPTY_ENTRY   - entry value presented at the queue head when it is empty
package ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IFU_MEM_LAST = 32'h0000_01FC;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Address 0 paired with NOP_WORD, so an empty queue reads as all zeros.
  localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0000_0000, instr: NOP_WORD};

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t used as the prefetch buffer.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset (empties the queue)
//   flush      in   empties the queue; takes priority over push and pop
//   push       in   enqueue push_entry (ignored when full unless popping)
//   push_entry in   entry written on push
//   pop        in   dequeue the head entry (ignored when empty)
//   head       out  current head entry, EMPTY_ENTRY when the queue is empty
//   count      out  occupancy 0..DEPTH
//   empty      out  count == 0
//   full       out  count == DEPTH
//
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
module fetch_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;

  logic do_pop;
  logic do_push;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A push into a full queue is accepted only when the head leaves the
  // same cycle, which frees the slot being written.
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  assign head  = empty ? EMPTY_ENTRY : mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch front end.
//
// Drives FetchPC into a combinational instruction memory, captures the
// returned word together with its address into a prefetch queue, and
// presents the queue head to decode.
//
// Ports:
//   CLK         in   clock
//   Reset       in   synchronous active-high reset
//   FetchPC     out  word-aligned address to instruction memory
//   FetchInstr  in   memory data for FetchPC, same cycle
//   Redirect    in   flush the queue and restart fetch at RedirectPC
//   RedirectPC  in   new fetch address, bits [1:0] ignored
//   InstrValid  out  head entry valid
//   InstrReady  in   decode accepts the head entry
//   InstrOut    out  head instruction word (0 when empty)
//   InstrPC     out  head instruction address (0 when empty)
//   FetchFault  out  sticky out-of-range fetch flag
//
// Handshake: the head entry transfers to decode on every rising edge where
// InstrValid & InstrReady are both high. While InstrValid is high and
// InstrReady is low, InstrOut/InstrPC hold steady. InstrValid never depends
// on InstrReady. A Redirect in the same cycle cancels the transfer.
//
// Build option: define IFU_RANGE_CHECK_EN to stop fetching at addresses
// above MEM_LAST and raise FetchFault. Without it FetchFault is always 0
// and every address is fetched.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter logic [31:0] MEM_LAST = IFU_MEM_LAST
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [31:0] FetchPC,
  input  logic [31:0] FetchInstr,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] InstrOut,
  output logic [31:0] InstrPC,
  output logic        FetchFault
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc_q;
  logic             fault_q;

  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic [CNT_W-1:0] q_count;
  logic             q_empty;
  logic             q_full;

  logic             pop;
  logic             push_attempt;
  logic             push;
  logic             fault_set;

  assign pop = InstrValid & InstrReady;

  // A fetch is attempted whenever the queue can take a word this cycle.
  assign push_attempt = !Redirect & !fault_q & (!q_full | pop);

`ifdef IFU_RANGE_CHECK_EN
  logic out_of_range;

  assign out_of_range = (fetch_pc_q > MEM_LAST);
  assign push         = push_attempt & !out_of_range;
  assign fault_set    = push_attempt & out_of_range;
`else
  logic [31:0] unused_mem_last;

  assign unused_mem_last = MEM_LAST;
  assign push            = push_attempt;
  assign fault_set       = 1'b0;
`endif

  assign push_entry = '{pc: fetch_pc_q, instr: FetchInstr};

  always_ff @(posedge CLK) begin
    if (Reset) begin
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      fault_q    <= 1'b0;
    end else if (Redirect) begin
      fetch_pc_q <= {RedirectPC[31:2], 2'b00};
      fault_q    <= 1'b0;
    end else begin
      if (push) begin
        // Wraps modulo 2^32.
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end
      if (fault_set) begin
        fault_q <= 1'b1;
      end
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (CLK),
    .reset     (Reset),
    .flush     (Redirect),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  logic [1:0] unused_redirect_lsbs;
  assign unused_redirect_lsbs = RedirectPC[1:0];

  assign FetchPC    = fetch_pc_q;
  assign InstrValid = !q_empty;
  assign InstrOut   = head.instr;
  assign InstrPC    = head.pc;
  assign FetchFault = fault_q;

endmodule
